jtag_drv_master: RTL

- On-chip JTAG initiator that drives the tck/tms/tdi/trst pins of the SPM test access port and samples its tdo.
- Lets management firmware (via Wishbone or LA glue) run IR/DR scans of the multiplier's scan chain without an external probe.
- Accepts one scan command at a time, generates the IEEE 1149.1 TMS sequence from Run-Test/Idle back to Run-Test/Idle, and returns the captured TDO bits.

---
 rtl/jtag_drv_master.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/jtag_drv_master.sv
// On-chip JTAG initiator: turns one scan command into an IEEE 1149.1 TMS/TDI
// sequence from Run-Test/Idle back to Run-Test/Idle and returns captured TDO.
module jtag_drv_master #(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [4:0]        cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  output logic              trst,
  input  logic              tdo
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, PREFIX, SEL, CAP, SHIFT, EXIT, UPD, DONE} state_t;
  typedef struct packed {
    state_t     st;
    logic [4:0] cnt;
  } step_t;

  state_t            st_q, st_d;
  logic [4:0]        cnt_q, cnt_d, idx_q, idx_d, len_q, len_s;
  logic [1:0]        op_q, op_s;
  logic [DATA_W-1:0] data_q, data_s, cap_q;
  logic [PW-1:0]     ph_q;
  logic              sync_q, tms_d, tdi_d, trst_d;
  logic              tck_q, tms_q, tdi_q, trst_q, ready_q, busy_q, rspv_q;
  logic [DATA_W-1:0] rsp_q;
  step_t             m;

  // First state of the scan body; cnt is the number of extra TCKs in that state.
  function automatic step_t main_step(input logic [1:0] op, input logic [4:0] len);
    step_t s;
    s.st  = DONE;
    s.cnt = len;
    case (op)
      2'b00: begin s.st = PREFIX; s.cnt = 5'd5; end
      2'b01: begin s.st = SEL;    s.cnt = 5'd1; end
      2'b10: begin s.st = SEL;    s.cnt = '0;   end
      default: ;
    endcase
    return s;
  endfunction

  always_comb begin
    op_s   = (st_q == IDLE) ? cmd_op   : op_q;
    len_s  = (st_q == IDLE) ? cmd_len  : len_q;
    data_s = (st_q == IDLE) ? cmd_data : data_q;
    m      = main_step(op_s, len_s);
    st_d   = st_q;
    cnt_d  = cnt_q - 5'd1;
    idx_d  = idx_q;
    if (st_q == IDLE) begin
      idx_d = '0;
      if (sync_q || cmd_op == 2'b00) begin
        st_d  = PREFIX;
        cnt_d = 5'd5;
      end else begin
        st_d  = m.st;
        cnt_d = m.cnt;
      end
    end else if (cnt_q != '0) begin
      if (st_q == SHIFT) idx_d = idx_q + 5'd1;
    end else begin
      cnt_d = '0;
      case (st_q)
        PREFIX: begin
          if (op_q == 2'b00) st_d = IDLE;
          else begin
            st_d  = m.st;
            cnt_d = m.cnt;
          end
        end
        SEL: begin st_d = CAP; cnt_d = 5'd1; end
        CAP: begin
          idx_d = '0;
          if (len_q == '0) st_d = EXIT;
          else begin
            st_d  = SHIFT;
            cnt_d = len_q - 5'd1;
          end
        end
        SHIFT: begin st_d = EXIT; idx_d = idx_q + 5'd1; end
        EXIT:  st_d = UPD;
        UPD:   st_d = DONE;
        default: st_d = IDLE;
      endcase
    end

    tms_d  = 1'b0;
    tdi_d  = 1'b0;
    trst_d = 1'b1;
    case (st_d)
      PREFIX: begin
        tms_d  = (cnt_d != '0);
        trst_d = !(op_s == 2'b00 && cnt_d != '0);
      end
      SEL, UPD: tms_d = 1'b1;
      SHIFT:    tdi_d = data_s[idx_d];
      EXIT: begin
        tms_d = 1'b1;
        tdi_d = data_s[idx_d];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      op_q    <= '0;
      len_q   <= '0;
      data_q  <= '0;
      cap_q   <= '0;
      ph_q    <= '0;
      sync_q  <= 1'b1;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      trst_q  <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      rspv_q  <= 1'b0;
      rsp_q   <= '0;
    end else begin
      rspv_q <= 1'b0;
      if (st_q == IDLE) begin
        ready_q <= 1'b1;
        if (cmd_valid && ready_q) begin
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
          op_q    <= cmd_op;
          len_q   <= cmd_len;
          data_q  <= cmd_data;
          cap_q   <= '0;
          ph_q    <= '0;
          tck_q   <= 1'b0;
          st_q    <= st_d;
          cnt_q   <= cnt_d;
          idx_q   <= idx_d;
          tms_q   <= tms_d;
          tdi_q   <= tdi_d;
          trst_q  <= trst_d;
        end
      end else if (ph_q == PW'(CLK_DIV - 1)) begin
        ph_q <= '0;
        if (!tck_q) begin
          tck_q <= 1'b1;
          if (st_q == SHIFT || st_q == EXIT) cap_q[idx_q] <= tdo;
        end else begin
          // End of a TCK period: present the next TCK's pins on the falling edge.
          tck_q  <= 1'b0;
          st_q   <= st_d;
          cnt_q  <= cnt_d;
          idx_q  <= idx_d;
          tms_q  <= tms_d;
          tdi_q  <= tdi_d;
          trst_q <= trst_d;
          if (st_q == PREFIX && cnt_q == '0) sync_q <= 1'b0;
          if (st_d == IDLE) begin
            busy_q <= 1'b0;
            rspv_q <= 1'b1;
            rsp_q  <= cap_q;
          end
        end
      end else begin
        ph_q <= ph_q + PW'(1);
      end
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rspv_q;
  assign rsp_data  = rsp_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;
  assign trst      = trst_q;

endmodule
